dataframe_sequencer: RTL and testbench
======================================

// Module: dataframe_sequencer
// PURPOSE
// - Single-channel frame sequencer. Sits after header_footer_gen's two FWFT FIFOs: the header/footer FIFO and the ADC FIFO.
// - Drains both FIFOs into one AXI4-Stream of DATA_WIDTH lines, in this order: header line 0, header line 1, payload, footer.
// - Asserts TLAST on the footer line and counts completed frames.
// PARAMETERS
// - DATA_WIDTH = 64: width of one output dataframe line.
// - ADC_WIDTH = 128: ADC FIFO word width; must equal 2*DATA_WIDTH.
// - HF_WIDTH = 192: header/footer FIFO word width, {hdr0, hdr1, footer}; must equal 3*DATA_WIDTH.
// - LEN_LSB = 144: bit position of the dataframe_len field in the HF word.
// - LEN_WIDTH = 12: width of the dataframe_len field; payload line count.
// - WATCHDOG_CYCLES = 1024: stall limit used only when DATAFRAME_WATCHDOG_EN is defined.
// PORTS
// - ACLK  in  1: clock.
// - ARESET  in  1: synchronous, active-high reset.
// - HF_FIFO_DOUT  in  HF_WIDTH: FWFT head word of the header/footer FIFO.
// - HF_FIFO_EMPTY  in  1: header/footer FIFO empty.
// - HF_FIFO_RD_EN  out  1: pop the header/footer FIFO.
// - ADC_FIFO_DOUT  in  ADC_WIDTH: FWFT head word of the ADC FIFO.
// - ADC_FIFO_EMPTY  in  1: ADC FIFO empty.
// - ADC_FIFO_RD_EN  out  1: pop the ADC FIFO.
// - M_AXIS_TDATA  out  DATA_WIDTH: output line.
// - M_AXIS_TVALID  out  1: output valid.
// - M_AXIS_TREADY  in  1: downstream ready.
// - M_AXIS_TLAST  out  1: high on the footer line only.
// - FRAME_CNT  out  32: number of completed frames; wraps 0xFFFFFFFF -> 0.
// - WATCHDOG_ERR  out  1: sticky error flag; always 0 when DATAFRAME_WATCHDOG_EN is not defined.
// BEHAVIOUR
// - Handshake: a line is accepted ("acc") in a cycle where TVALID & TREADY. TVALID/TDATA/TLAST are decoded from registered state plus FIFO DOUT/EMPTY only; there is no path from TREADY to TVALID.
// - Reset (ARESET=1): state=IDLE; line counter=0; FRAME_CNT=0; WATCHDOG_ERR=0. This forces TVALID=0, TLAST=0, TDATA=0, and both RD_EN=0.
// - Reset mid-frame: the frame is abandoned and no FIFO is popped. FIFO flushing is the owner's job.
// - FSM states: IDLE, HDR0, HDR1, PAY_HI, PAY_LO, FTR.
//   - IDLE: TVALID=0. Go to HDR0 the cycle after HF_FIFO_EMPTY=0, so TVALID rises 1 cycle after the FIFO goes non-empty.
//   - HDR0: TDATA=HF_FIFO_DOUT[191:128]. On acc, latch len=HF_FIFO_DOUT[LEN_LSB+:LEN_WIDTH] and go to HDR1.
//   - HDR1: TDATA=HF_FIFO_DOUT[127:64]. On acc, go to FTR if len==0, else to PAY_HI.
//   - PAY_HI: TVALID=!ADC_FIFO_EMPTY; TDATA=ADC_FIFO_DOUT[127:64].
//   - PAY_LO: TVALID=1 (the ADC word is still at the head); TDATA=ADC_FIFO_DOUT[63:0].
//   - FTR: TDATA=HF_FIFO_DOUT[63:0]; TLAST=1. On acc, HF_FIFO_RD_EN=1 for exactly that cycle, FRAME_CNT+1, then go to IDLE.
// - Payload counting: the line counter counts payload lines accepted.
//   - On acc of the last line (counter==len-1), go to FTR.
//   - Otherwise, PAY_HI goes to PAY_LO and PAY_LO goes to PAY_HI.
// - ADC pop rule: ADC_FIFO_RD_EN=1 on acc in PAY_LO.
//   - If len is odd, it is also 1 on acc of the final line in PAY_HI, so the unused low half is dropped.
//   - Exactly ceil(len/2) ADC words are popped per frame.
// - HF word is never popped before the footer is accepted (FWFT head stays stable).
// - Back-to-back frames: IDLE lasts 1 cycle minimum, so the inter-frame gap is exactly 1 cycle.
// - TREADY low holds TDATA/TVALID/state. An empty ADC FIFO in PAY_HI is a bubble (TVALID=0), not an error.
// - Width checks: len max 4095. The counter is LEN_WIDTH bits and never wraps inside a frame.
// CONFIGURATION
// - DATAFRAME_WATCHDOG_EN defined:
//   - A stall counter increments each cycle in PAY_HI with ADC_FIFO_EMPTY=1, and clears on any acc.
//   - When it reaches WATCHDOG_CYCLES, set WATCHDOG_ERR (sticky until ARESET) and enter pad mode.
//   - Pad mode: remaining payload lines are driven as all-ones with TVALID=1 and no ADC pops; the footer follows normally.
// - DATAFRAME_WATCHDOG_EN undefined: the block waits indefinitely in PAY_HI; WATCHDOG_ERR is tied 0; WATCHDOG_CYCLES is unused.
// TESTING
// - Basic frame: HF word with len=4, 2 ADC words, TREADY=1.
//   - Expect 7 lines hdr0, hdr1, A0hi, A0lo, A1hi, A1lo, ftr; TLAST only on ftr.
//   - Expect ADC_FIFO_RD_EN 2 pulses, HF_FIFO_RD_EN 1 pulse, FRAME_CNT=1.
// - Odd and zero length:
//   - len=3: 3 payload lines, 2 ADC pops, A1lo never output.
//   - len=0: exactly 3 lines hdr0, hdr1, ftr; 0 ADC pops.
// - Backpressure: TREADY toggled 1010..., plus ADC_FIFO_EMPTY=1 for 5 cycles mid-payload.
//   - Expect identical line sequence, TDATA stable while TVALID&!TREADY, and TVALID=0 during the empty gap.
// - Reset mid-frame: assert ARESET in PAY_LO.
//   - Next cycle: TVALID=0, FRAME_CNT=0, no RD_EN pulse.
//   - After release with a refilled FIFO, a clean frame starts at HDR0.
// - Throughput/wrap: 3 queued len=2 frames with TREADY=1 give 5-line frames separated by 1 idle cycle. Force FRAME_CNT=0xFFFFFFFF; the next footer gives 0.
// - Watchdog (macro on, WATCHDOG_CYCLES=8): len=4 with only 1 ADC word.
//   - After 8 stall cycles, WATCHDOG_ERR=1 and lines 3-4 are 0xFFFFFFFFFFFFFFFF; footer follows with TLAST.
//   - Macro off: block waits indefinitely and WATCHDOG_ERR stays 0.

Source files
------------

// File: rtl/dataframe_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// dataframe_sequencer_if : FIFO-side and AXI4-Stream-side bus | rev 1.0
// ------------------------------------------------------------------------
interface dataframe_sequencer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADC_WIDTH  = 128,
   parameter int HF_WIDTH   = 192
);
   logic [HF_WIDTH-1:0]   HF_FIFO_DOUT;
   logic                  HF_FIFO_EMPTY;
   logic                  HF_FIFO_RD_EN;
   logic [ADC_WIDTH-1:0]  ADC_FIFO_DOUT;
   logic                  ADC_FIFO_EMPTY;
   logic                  ADC_FIFO_RD_EN;
   logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
   logic                  M_AXIS_TVALID;
   logic                  M_AXIS_TREADY;
   logic                  M_AXIS_TLAST;

   modport master (
      input  HF_FIFO_DOUT, HF_FIFO_EMPTY, ADC_FIFO_DOUT, ADC_FIFO_EMPTY, M_AXIS_TREADY,
      output HF_FIFO_RD_EN, ADC_FIFO_RD_EN, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
   );

   modport slave (
      output HF_FIFO_DOUT, HF_FIFO_EMPTY, ADC_FIFO_DOUT, ADC_FIFO_EMPTY, M_AXIS_TREADY,
      input  HF_FIFO_RD_EN, ADC_FIFO_RD_EN, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
   );
endinterface
`default_nettype wire

// File: rtl/dataframe_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// dataframe_sequencer : drains header/footer + ADC FIFOs into one framed
// AXI4-Stream | rev 1.0 | optional macro: DATAFRAME_WATCHDOG_EN
// ------------------------------------------------------------------------
module dataframe_sequencer #(
   parameter int DATA_WIDTH      = 64,
   parameter int ADC_WIDTH       = 128,
   parameter int HF_WIDTH        = 192,
   parameter int LEN_LSB         = 144,
   parameter int LEN_WIDTH       = 12,
   parameter int WATCHDOG_CYCLES = 1024
) (
   input  wire logic              ACLK,
   input  wire logic              ARESET,
   dataframe_sequencer_if.master  bus,
   output logic [31:0]            FRAME_CNT,
   output logic                   WATCHDOG_ERR
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR0   = 3'd1,
      S_HDR1   = 3'd2,
      S_PAY_HI = 3'd3,
      S_PAY_LO = 3'd4,
      S_FTR    = 3'd5
   } state_t;

   if (ADC_WIDTH != 2 * DATA_WIDTH) begin : g_chk_adc_width
      $error("ADC_WIDTH must equal 2*DATA_WIDTH");
   end
   if (HF_WIDTH != 3 * DATA_WIDTH) begin : g_chk_hf_width
      $error("HF_WIDTH must equal 3*DATA_WIDTH");
   end
   if (WATCHDOG_CYCLES < 1) begin : g_chk_wd_cycles
      $error("WATCHDOG_CYCLES must be at least 1");
   end

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [31:0]           frame_cnt_q, frame_cnt_d;

   logic                  w_valid;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_last;
   logic                  w_acc;
   logic                  w_hf_rd;
   logic                  w_adc_rd;
   logic                  w_pad;
   logic                  w_last_line;

   // len never exceeds 4095, so cnt+1 cannot wrap before matching len
   assign w_last_line = (cnt_q + LEN_WIDTH'(1)) == len_q;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      w_valid     = 1'b0;
      w_data      = '0;
      w_last      = 1'b0;
      w_hf_rd     = 1'b0;
      w_adc_rd    = 1'b0;

      case (state_q)
         S_HDR0: begin
            w_valid = 1'b1;
            w_data  = bus.HF_FIFO_DOUT[HF_WIDTH-1 -: DATA_WIDTH];
         end
         S_HDR1: begin
            w_valid = 1'b1;
            w_data  = bus.HF_FIFO_DOUT[HF_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
         end
         S_PAY_HI: begin
            w_valid = w_pad | ~bus.ADC_FIFO_EMPTY;
            w_data  = w_pad ? {DATA_WIDTH{1'b1}} : bus.ADC_FIFO_DOUT[ADC_WIDTH-1 -: DATA_WIDTH];
         end
         S_PAY_LO: begin
            w_valid = 1'b1;
            w_data  = w_pad ? {DATA_WIDTH{1'b1}} : bus.ADC_FIFO_DOUT[DATA_WIDTH-1:0];
         end
         S_FTR: begin
            w_valid = 1'b1;
            w_last  = 1'b1;
            w_data  = bus.HF_FIFO_DOUT[DATA_WIDTH-1:0];
         end
         default: ;
      endcase

      w_acc = w_valid & bus.M_AXIS_TREADY;

      case (state_q)
         S_IDLE: begin
            if (!bus.HF_FIFO_EMPTY) state_d = S_HDR0;
         end
         S_HDR0: begin
            if (w_acc) begin
               len_d   = bus.HF_FIFO_DOUT[LEN_LSB +: LEN_WIDTH];
               state_d = S_HDR1;
            end
         end
         S_HDR1: begin
            if (w_acc) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? S_FTR : S_PAY_HI;
            end
         end
         S_PAY_HI: begin
            if (w_acc) begin
               cnt_d = cnt_q + LEN_WIDTH'(1);
               if (w_last_line) begin
                  // odd length: drop the unused low half with the pop
                  w_adc_rd = ~w_pad;
                  state_d  = S_FTR;
               end else begin
                  state_d  = S_PAY_LO;
               end
            end
         end
         S_PAY_LO: begin
            if (w_acc) begin
               w_adc_rd = ~w_pad;
               cnt_d    = cnt_q + LEN_WIDTH'(1);
               state_d  = w_last_line ? S_FTR : S_PAY_HI;
            end
         end
         S_FTR: begin
            if (w_acc) begin
               w_hf_rd     = 1'b1;
               frame_cnt_d = frame_cnt_q + 32'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

`ifdef DATAFRAME_WATCHDOG_EN
   localparam int STALL_W = $clog2(WATCHDOG_CYCLES + 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               pad_q, pad_d;
   logic               wd_err_q, wd_err_d;

   always_comb begin
      stall_d  = stall_q;
      pad_d    = pad_q;
      wd_err_d = wd_err_q;
      if (w_acc) begin
         stall_d = '0;
      end else if (state_q == S_PAY_HI && bus.ADC_FIFO_EMPTY && !pad_q) begin
         stall_d = stall_q + STALL_W'(1);
      end
      if (stall_d == STALL_W'(WATCHDOG_CYCLES)) begin
         stall_d  = '0;
         pad_d    = 1'b1;
         wd_err_d = 1'b1;
      end
      if (state_q == S_IDLE) pad_d = 1'b0;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         stall_q  <= '0;
         pad_q    <= 1'b0;
         wd_err_q <= 1'b0;
      end else begin
         stall_q  <= stall_d;
         pad_q    <= pad_d;
         wd_err_q <= wd_err_d;
      end
   end

   assign w_pad        = pad_q;
   assign WATCHDOG_ERR = wd_err_q;
`else
   assign w_pad        = 1'b0;
   assign WATCHDOG_ERR = 1'b0;
`endif

   // reset gating keeps an abandoned frame from popping either FIFO
   assign bus.M_AXIS_TVALID  = w_valid & ~ARESET;
   assign bus.M_AXIS_TLAST   = w_last & ~ARESET;
   assign bus.M_AXIS_TDATA   = ARESET ? '0 : w_data;
   assign bus.HF_FIFO_RD_EN  = w_hf_rd & ~ARESET;
   assign bus.ADC_FIFO_RD_EN = w_adc_rd & ~ARESET;
   assign FRAME_CNT          = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dataframe_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_dataframe_sequencer : FIFO models, line scoreboard and frame vectors
// ------------------------------------------------------------------------
module tb_dataframe_sequencer;
   localparam int DW = 64;
   localparam int AW = 128;
   localparam int HW = 192;
   localparam int LEN_LSB = 144;
   localparam int LEN_WIDTH = 12;
`ifdef DATAFRAME_WATCHDOG_EN
   localparam int WD_LIMIT = 8;
`else
   localparam int WD_LIMIT = 1 << 30;
`endif

   typedef struct {
      logic [DW-1:0] data;
      bit            last;
      int            kind;   // 0 header/footer, 1 payload high, 2 payload low
      bit            first;
   } exp_t;

   typedef struct {
      int len; int n_adc; bit bp; int gap_after; int gap_len; bit stall;
      int exp_lines; int exp_pops;
   } vec_t;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [31:0] frame_cnt;
   logic        wd_err;

   always #5 ACLK = ~ACLK;

   dataframe_sequencer_if #(.DATA_WIDTH(DW), .ADC_WIDTH(AW), .HF_WIDTH(HW)) bus ();

   dataframe_sequencer #(
      .DATA_WIDTH(DW), .ADC_WIDTH(AW), .HF_WIDTH(HW),
      .LEN_LSB(LEN_LSB), .LEN_WIDTH(LEN_WIDTH), .WATCHDOG_CYCLES(8)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .bus(bus),
      .FRAME_CNT(frame_cnt), .WATCHDOG_ERR(wd_err)
   );

   int errors = 0;
   int checks = 0;
   exp_t exp_q[$];
   logic [HW-1:0] hf_q[$];
   logic [AW-1:0] adc_q[$];
   int line_cnt, adc_pops, hf_pops, cycle = 0;
   bit prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   int gap_cnt = 0, gap_after = 0, gap_len = 0, stall_seen = 0;
   bit gap_arm = 1'b0, bp_mode = 1'b0, gap_check_en = 1'b0, wd_expect = 1'b0;
   int last_ftr_cyc = -1, last_acc_cyc = 0;
   logic [31:0] exp_frames = '0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic drive_fifos();
      bus.HF_FIFO_EMPTY  = (hf_q.size() == 0);
      bus.HF_FIFO_DOUT   = (hf_q.size() != 0) ? hf_q[0] : '0;
      bus.ADC_FIFO_EMPTY = (adc_q.size() == 0) || (gap_cnt > 0);
      bus.ADC_FIFO_DOUT  = (adc_q.size() != 0) ? adc_q[0] : '0;
   endtask

   task automatic step();
      exp_t e;
      bit acc, p_hf, p_adc;
      @(negedge ACLK);
      acc = bus.M_AXIS_TVALID && bus.M_AXIS_TREADY;
      if (prev_stall && !ARESET) begin
         chk("hold_tvalid", 64'(bus.M_AXIS_TVALID), 64'd1);
         chk("hold_tdata", bus.M_AXIS_TDATA, prev_data);
      end
      if (!ARESET && bus.ADC_FIFO_EMPTY && exp_q.size() != 0 && exp_q[0].kind == 1) begin
         if (stall_seen < WD_LIMIT) chk("bubble_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
         stall_seen++;
      end
      if (acc) begin
         stall_seen = 0;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_line: got %0h expected no line", bus.M_AXIS_TDATA);
         end else begin
            e = exp_q.pop_front();
            chk("tdata", bus.M_AXIS_TDATA, e.data);
            chk("tlast", 64'(bus.M_AXIS_TLAST), 64'(e.last));
            if (gap_check_en) begin
               if (e.first && last_ftr_cyc >= 0)
                  chk("interframe_gap", 64'(cycle - last_ftr_cyc), 64'd2);
               else if (!e.first)
                  chk("line_spacing", 64'(cycle - last_acc_cyc), 64'd1);
            end
            if (e.last) last_ftr_cyc = cycle;
            last_acc_cyc = cycle;
         end
         line_cnt++;
      end
      p_hf  = bus.HF_FIFO_RD_EN;
      p_adc = bus.ADC_FIFO_RD_EN;
      if (p_hf)  hf_pops++;
      if (p_adc) adc_pops++;
      prev_stall = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
      prev_data  = bus.M_AXIS_TDATA;
      @(posedge ACLK);
      #1;
      if (p_hf) begin
         if (hf_q.size() != 0) void'(hf_q.pop_front());
         else begin checks++; errors++; $display("FAIL hf_pop_empty: got pop expected none"); end
      end
      if (p_adc) begin
         if (adc_q.size() != 0) void'(adc_q.pop_front());
         else begin checks++; errors++; $display("FAIL adc_pop_empty: got pop expected none"); end
      end
      cycle++;
      if (gap_cnt > 0) gap_cnt--;
      if (gap_arm && line_cnt >= gap_after) begin
         gap_cnt = gap_len;
         gap_arm = 1'b0;
      end
      bus.M_AXIS_TREADY = bp_mode ? ~bus.M_AXIS_TREADY : 1'b1;
      drive_fifos();
   endtask

   task automatic push_frame(input int len, input int n_adc, input bit stall_pad);
      logic [DW-1:0] h0, h1, ft, d;
      logic [HW-1:0] w;
      logic [AW-1:0] a[$];
      h0 = {$urandom, $urandom};
      h1 = {$urandom, $urandom};
      ft = {$urandom, $urandom};
      w = {h0, h1, ft};
      w[LEN_LSB +: LEN_WIDTH] = len[LEN_WIDTH-1:0];
      h0 = w[HW-1 -: DW];
      for (int k = 0; k < n_adc; k++) begin
         a.push_back({$urandom, $urandom, $urandom, $urandom});
         adc_q.push_back(a[k]);
      end
      exp_q.push_back('{h0, 1'b0, 0, 1'b1});
      exp_q.push_back('{h1, 1'b0, 0, 1'b0});
      for (int k = 0; k < len; k++) begin
         if (stall_pad && k >= 2) d = '1;
         else if (k % 2 == 0)    d = a[k/2][AW-1 -: DW];
         else                    d = a[k/2][DW-1:0];
         exp_q.push_back('{d, 1'b0, (k % 2 == 0) ? 1 : 2, 1'b0});
      end
      exp_q.push_back('{ft, 1'b1, 0, 1'b0});
      hf_q.push_back(w);
   endtask

   task automatic run_vec(input vec_t v);
      bit pad_flag;
`ifdef DATAFRAME_WATCHDOG_EN
      pad_flag = v.stall;
`else
      pad_flag = 1'b0;
`endif
      line_cnt = 0; adc_pops = 0; hf_pops = 0;
      push_frame(v.len, v.n_adc, pad_flag);
      bp_mode   = v.bp;
      gap_arm   = (v.gap_after > 0);
      gap_after = v.gap_after;
      gap_len   = v.gap_len;
      drive_fifos();
      for (int c = 0; c < 300 && hf_pops == 0; c++) step();
      if (hf_pops == 0) begin
         checks++; errors++;
         $display("FAIL frame_timeout: got no footer expected footer within 300 cycles");
      end
      exp_frames = exp_frames + 32'd1;
      if (pad_flag) wd_expect = 1'b1;
      chk("line_count", 64'(line_cnt), 64'(v.exp_lines));
      chk("adc_pops", 64'(adc_pops), 64'(v.exp_pops));
      chk("hf_pops", 64'(hf_pops), 64'd1);
      chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("watchdog_err", 64'(wd_err), 64'(wd_expect));
      bp_mode = 1'b0;
      gap_arm = 1'b0;
      bus.M_AXIS_TREADY = 1'b1;
      if (pad_flag) begin
         adc_q.delete();
         gap_cnt = 0;
      end
      drive_fifos();
   endtask

   initial begin
      vec_t vt[6];
      int saved;
      vt[0] = '{4, 2, 1'b0, 0, 0, 1'b0, 7, 2};    // basic frame
      vt[1] = '{3, 2, 1'b0, 0, 0, 1'b0, 6, 2};    // odd length
      vt[2] = '{0, 0, 1'b0, 0, 0, 1'b0, 3, 0};    // empty payload
      vt[3] = '{4, 2, 1'b1, 4, 5, 1'b0, 7, 2};    // backpressure + 5-cycle ADC gap
      vt[4] = '{1, 1, 1'b1, 0, 0, 1'b0, 4, 1};    // single payload line
`ifdef DATAFRAME_WATCHDOG_EN
      vt[5] = '{4, 2, 1'b0, 4, 20, 1'b1, 7, 1};   // stall -> pad mode
`else
      vt[5] = '{4, 2, 1'b0, 4, 20, 1'b1, 7, 2};   // stall -> indefinite wait
`endif

      bus.M_AXIS_TREADY = 1'b1;
      drive_fifos();
      repeat (3) @(posedge ACLK);
      #1;
      hf_q.push_back('1);   // a non-empty FIFO must not wake the block while held in reset
      drive_fifos();
      @(negedge ACLK);
      chk("rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
      chk("rst_tlast", 64'(bus.M_AXIS_TLAST), 64'd0);
      chk("rst_tdata", bus.M_AXIS_TDATA, 64'd0);
      chk("rst_rd_en", 64'({bus.HF_FIFO_RD_EN, bus.ADC_FIFO_RD_EN}), 64'd0);
      @(posedge ACLK);
      #1;
      hf_q.delete();
      ARESET = 1'b0;
      drive_fifos();
      step();
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_wd_err", 64'(wd_err), 64'd0);
      chk("idle_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);

      for (int i = 0; i < 6; i++) run_vec(vt[i]);

      // reset while the low half of the first ADC word is presented
      line_cnt = 0; adc_pops = 0; hf_pops = 0;
      push_frame(4, 2, 1'b0);
      drive_fifos();
      for (int c = 0; c < 50 && line_cnt < 3; c++) step();
      chk("pre_reset_lines", 64'(line_cnt), 64'd3);
      saved = adc_pops + hf_pops;
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      chk("reset_no_pop", 64'(adc_pops + hf_pops), 64'(saved));
      hf_q.delete(); adc_q.delete(); exp_q.delete();
      exp_frames = '0;
      wd_expect = 1'b0;
      drive_fifos();
      step();
      chk("post_rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
      chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("post_rst_no_pop", 64'(adc_pops + hf_pops), 64'(saved));
      chk("post_rst_wd_err", 64'(wd_err), 64'd0);
      run_vec(vt[0]);

      // three queued frames at full throughput
      line_cnt = 0; adc_pops = 0; hf_pops = 0;
      gap_check_en = 1'b1;
      last_ftr_cyc = -1;
      for (int f = 0; f < 3; f++) push_frame(2, 1, 1'b0);
      drive_fifos();
      for (int c = 0; c < 100 && hf_pops < 3; c++) step();
      gap_check_en = 1'b0;
      exp_frames = exp_frames + 32'd3;
      chk("tput_lines", 64'(line_cnt), 64'd15);
      chk("tput_hf_pops", 64'(hf_pops), 64'd3);
      chk("tput_adc_pops", 64'(adc_pops), 64'd3);
      chk("tput_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

      // frame counter wrap
      force dut.frame_cnt_q = 32'hFFFF_FFFF;
      step();
      release dut.frame_cnt_q;
      exp_frames = 32'hFFFF_FFFF;
      run_vec(vt[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
